// File: rtl/pdm_mic_receiver.sv
// -----------------------------------------------------------------------------
// pdm_mic_receiver
//
// Generates the clock for a PDM MEMS microphone and samples its 1-bit stream.
// A 3rd-order CIC decimator (differential delay 1) turns the stream into
// signed PCM words, which are handed out over a valid/ready interface.
//
// Optional feature macro: PDM_DC_BLOCK_EN
//   defined     -> a DC-blocking high-pass stage follows the CIC truncation.
//                  It adds one cycle of latency.
//   not defined -> the truncated CIC output drives the sample register directly.
//
// Parameters
//   CLK_DIV   : mic_clk period in clk_100mhz cycles (even, >= 8)
//   DECIM     : CIC decimation ratio (power of two, >= 4)
//   OUT_WIDTH : PCM width, <= W where W = 2 + 3*log2(DECIM)
//
// Ports
//   clk_100mhz   in   system clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   run decoder; low clears every register synchronously
//   mic_data     in   PDM data from the microphone (asynchronous)
//   mic_clk      out  microphone clock, 50% duty
//   sample       out  signed PCM sample, stable while sample_valid is high
//   sample_valid out  sample available
//   sample_ready in   consumer accepts the sample
//   overrun      out  sticky: an unaccepted sample was overwritten
// -----------------------------------------------------------------------------
module pdm_mic_receiver #(
    parameter int CLK_DIV   = 40,
    parameter int DECIM     = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk_100mhz,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 mic_data,
    output logic                 mic_clk,
    output logic [OUT_WIDTH-1:0] sample,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun
);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int DEC_W  = $clog2(DECIM);
    localparam int W      = 2 + 3 * DEC_W;
    localparam int SHIFT  = W - OUT_WIDTH;
    localparam int NSTAGE = 3;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);

    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic                 mic_clk_q, mic_clk_d;
    logic [1:0]           sync_q, sync_d;
    logic [DEC_W-1:0]     dec_cnt_q, dec_cnt_d;
    logic [W-1:0]         integ_q     [NSTAGE];
    logic [W-1:0]         integ_d     [NSTAGE];
    logic [W-1:0]         comb_q      [NSTAGE];
    logic [W-1:0]         comb_d      [NSTAGE];
    logic [W-1:0]         comb_prev_q [NSTAGE];
    logic [W-1:0]         comb_prev_d [NSTAGE];
    logic [NSTAGE-1:0]    comb_vld_q, comb_vld_d;
    logic [OUT_WIDTH-1:0] sample_q, sample_d;
    logic                 sample_valid_q, sample_valid_d;
    logic                 overrun_q, overrun_d;

    logic                 capture;
    logic                 dec_fire;
    logic                 xfer;
    logic [W-1:0]         x_step;
    logic [OUT_WIDTH-1:0] trunc_word;
    logic [OUT_WIDTH-1:0] load_word;
    logic                 load;

    // Keep the top OUT_WIDTH bits of the last comb stage (plain truncation).
    assign trunc_word = OUT_WIDTH'(comb_q[NSTAGE-1] >> SHIFT);

`ifdef PDM_DC_BLOCK_EN
    // y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8), computed in a wider
    // accumulator and saturated on the way out.
    localparam int AW = OUT_WIDTH + 4;
    localparam logic signed [AW-1:0] SAT_MAX = {5'b00000, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {5'b11111, {(OUT_WIDTH-1){1'b0}}};

    logic signed [AW-1:0]  dc_y_q, dc_y_d;
    logic signed [AW-1:0]  dc_x_ext, dc_xp_ext, dc_decay, dc_y_new;
    logic [OUT_WIDTH-1:0]  dc_x_prev_q, dc_x_prev_d;
    logic [OUT_WIDTH-1:0]  dc_out_q, dc_out_d;
    logic                  dc_vld_q, dc_vld_d;

    always_comb begin
        dc_x_ext    = {{4{trunc_word[OUT_WIDTH-1]}}, trunc_word};
        dc_xp_ext   = {{4{dc_x_prev_q[OUT_WIDTH-1]}}, dc_x_prev_q};
        dc_decay    = dc_y_q >>> 8;
        dc_y_new    = dc_x_ext - dc_xp_ext + dc_y_q - dc_decay;
        dc_y_d      = dc_y_q;
        dc_x_prev_d = dc_x_prev_q;
        dc_out_d    = dc_out_q;
        dc_vld_d    = comb_vld_q[NSTAGE-1];
        if (comb_vld_q[NSTAGE-1]) begin
            dc_y_d      = dc_y_new;
            dc_x_prev_d = trunc_word;
            if (dc_y_new > SAT_MAX) begin
                dc_out_d = SAT_MAX[OUT_WIDTH-1:0];
            end else if (dc_y_new < SAT_MIN) begin
                dc_out_d = SAT_MIN[OUT_WIDTH-1:0];
            end else begin
                dc_out_d = dc_y_new[OUT_WIDTH-1:0];
            end
        end
        if (!enable) begin
            dc_y_d      = '0;
            dc_x_prev_d = '0;
            dc_out_d    = '0;
            dc_vld_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            dc_y_q      <= '0;
            dc_x_prev_q <= '0;
            dc_out_q    <= '0;
            dc_vld_q    <= 1'b0;
        end else begin
            dc_y_q      <= dc_y_d;
            dc_x_prev_q <= dc_x_prev_d;
            dc_out_q    <= dc_out_d;
            dc_vld_q    <= dc_vld_d;
        end
    end

    assign load      = dc_vld_q;
    assign load_word = dc_out_q;
`else
    assign load      = comb_vld_q[NSTAGE-1];
    assign load_word = trunc_word;
`endif

    always_comb begin
        // The last cycle of the mic_clk high phase is the capture point.
        capture  = (div_cnt_q == DIV_LAST);
        dec_fire = capture && (dec_cnt_q == DEC_LAST);
        xfer     = sample_valid_q && sample_ready;
        x_step   = sync_q[1] ? W'(1) : {W{1'b1}};

        div_cnt_d = capture ? '0 : div_cnt_q + DIV_W'(1);
        // Derived from the next count so mic_clk tracks div_cnt exactly.
        mic_clk_d = (div_cnt_d >= DIV_HALF);
        sync_d    = {sync_q[0], mic_data};

        dec_cnt_d = dec_cnt_q;
        if (capture) begin
            dec_cnt_d = dec_fire ? '0 : dec_cnt_q + DEC_W'(1);
        end

        // Integrators wrap freely; the combs cancel the wrap.
        for (int k = 0; k < NSTAGE; k++) begin
            integ_d[k] = integ_q[k];
        end
        if (capture) begin
            integ_d[0] = integ_q[0] + x_step;
            for (int k = 1; k < NSTAGE; k++) begin
                integ_d[k] = integ_q[k] + integ_d[k-1];
            end
        end

        // Comb pipeline: one stage per cycle, history advances only with data.
        for (int k = 0; k < NSTAGE; k++) begin
            comb_d[k]      = comb_q[k];
            comb_prev_d[k] = comb_prev_q[k];
        end
        comb_vld_d[0] = dec_fire;
        if (dec_fire) begin
            comb_d[0]      = integ_d[NSTAGE-1] - comb_prev_q[0];
            comb_prev_d[0] = integ_d[NSTAGE-1];
        end
        for (int k = 1; k < NSTAGE; k++) begin
            comb_vld_d[k] = comb_vld_q[k-1];
            if (comb_vld_q[k-1]) begin
                comb_d[k]      = comb_q[k-1] - comb_prev_q[k];
                comb_prev_d[k] = comb_q[k-1];
            end
        end

        // Output register and handshake. A load in a transfer cycle replaces
        // the word just taken, so valid stays up and no overrun is flagged.
        sample_d       = sample_q;
        sample_valid_d = sample_valid_q;
        overrun_d      = overrun_q;
        if (load) begin
            sample_d       = load_word;
            sample_valid_d = 1'b1;
            if (sample_valid_q && !xfer) begin
                overrun_d = 1'b1;
            end
        end else if (xfer) begin
            sample_valid_d = 1'b0;
        end

        if (!enable) begin
            div_cnt_d      = '0;
            mic_clk_d      = 1'b0;
            sync_d         = '0;
            dec_cnt_d      = '0;
            comb_vld_d     = '0;
            sample_d       = '0;
            sample_valid_d = 1'b0;
            overrun_d      = 1'b0;
            for (int k = 0; k < NSTAGE; k++) begin
                integ_d[k]     = '0;
                comb_d[k]      = '0;
                comb_prev_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q      <= '0;
            mic_clk_q      <= 1'b0;
            sync_q         <= '0;
            dec_cnt_q      <= '0;
            comb_vld_q     <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            for (int k = 0; k < NSTAGE; k++) begin
                integ_q[k]     <= '0;
                comb_q[k]      <= '0;
                comb_prev_q[k] <= '0;
            end
        end else begin
            div_cnt_q      <= div_cnt_d;
            mic_clk_q      <= mic_clk_d;
            sync_q         <= sync_d;
            dec_cnt_q      <= dec_cnt_d;
            comb_vld_q     <= comb_vld_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
            for (int k = 0; k < NSTAGE; k++) begin
                integ_q[k]     <= integ_d[k];
                comb_q[k]      <= comb_d[k];
                comb_prev_q[k] <= comb_prev_d[k];
            end
        end
    end

    assign mic_clk      = mic_clk_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_pdm_mic_receiver.sv
// -----------------------------------------------------------------------------
// tb_pdm_mic_receiver
//
// Scoreboard bench for pdm_mic_receiver. A short mic_clk period keeps the run
// compact; DECIM and OUT_WIDTH stay at their defaults so full scale is +/-16384.
// Expected samples are queued when a stimulus run starts and popped on every
// valid/ready transfer.
// -----------------------------------------------------------------------------
module tb_pdm_mic_receiver;
    localparam int CLK_DIV   = 8;
    localparam int DECIM     = 64;
    localparam int OUT_WIDTH = 16;
    localparam int FULL      = 16384;
    localparam int PERIOD    = CLK_DIV * DECIM;
`ifdef PDM_DC_BLOCK_EN
    localparam int LAT   = 5;
    localparam int KPOS  = 2;   // non-increasing vs previous sample
    localparam int KNEG  = 3;   // non-decreasing vs previous sample
    localparam int KZERO = 0;   // not checked
`else
    localparam int LAT   = 4;
    localparam int KPOS  = 1;   // exact value
    localparam int KNEG  = 1;
    localparam int KZERO = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable = 1'b0;
    logic                 mic_data = 1'b0;
    logic                 sample_ready = 1'b0;
    logic                 mic_clk;
    logic [OUT_WIDTH-1:0] sample;
    logic                 sample_valid;
    logic                 overrun;

    pdm_mic_receiver #(
        .CLK_DIV   (CLK_DIV),
        .DECIM     (DECIM),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .clk_100mhz   (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mic_data     (mic_data),
        .mic_clk      (mic_clk),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int kind;   // 0 skip, 1 exact, 2 <= previous, 3 >= previous
        int val;
    } exp_t;
    exp_t exp_q[$];

    task automatic push(input int kind, input int val, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.kind = kind;
            e.val  = val;
            exp_q.push_back(e);
        end
    endtask

    // 0: constant 0, 1: constant 1, 2: alternate each mic_clk period
    int mode = 0;
    initial begin
        forever begin
            @(posedge mic_clk);
            #3;
            if (mode == 2) mic_data = ~mic_data;
            else           mic_data = (mode == 1);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor: sampled on the falling edge, away from DUT updates.
    int   last_fall  = 0;
    logic prev_mic   = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_xfer  = 1'b0;
    int   prev_s     = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        int   s;
        s = int'($signed(sample));
        if (prev_mic && !mic_clk) last_fall = cyc;
        if (rst_n && sample_valid && !prev_valid)
            check("capture_to_valid", cyc - (last_fall - 1), LAT);
        if (prev_xfer)
            check("valid_pulse", int'(sample_valid), 0);
        if (rst_n && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", s, 0);
                check("unexpected_sample_flag", 1, 0);
            end else begin
                e = exp_q.pop_front();
                if (e.kind == 1) check("sample", s, e.val);
                if (e.kind == 2) check("decay_down", int'(s <= prev_s), 1);
                if (e.kind == 3) check("decay_up", int'(s >= prev_s), 1);
            end
            prev_s = s;
        end
        prev_xfer  = rst_n && sample_valid && sample_ready;
        prev_valid = sample_valid;
        prev_mic   = mic_clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < max_cyc) begin
            step();
            c++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic start(input int m);
        step();
        enable       = 1'b0;
        mode         = m;
        mic_data     = (m == 1);
        sample_ready = 1'b1;
        repeat (4) step();
        check("idle_valid", int'(sample_valid), 0);
        check("idle_overrun", int'(overrun), 0);
        check("idle_mic_clk", int'(mic_clk), 0);
        enable = 1'b1;
    endtask

    initial begin : watchdog
        #(95000 * 10);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int k;
        int h;

        // Reset state
        repeat (3) step();
        check("rst_mic_clk", int'(mic_clk), 0);
        check("rst_sample", int'(sample), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;

        // Divider: idle while enable low, then first rise and 50% duty
        h = 0;
        for (int i = 0; i < 2 * CLK_DIV; i++) begin
            step();
            if (mic_clk) h++;
        end
        check("mic_clk_idle_highs", h, 0);
        enable = 1'b1;
        k = 0;
        do begin step(); k++; end while (!mic_clk && k < 100);
        check("first_rise", k, CLK_DIV / 2);
        h = 0;
        while (mic_clk && h < 100) begin step(); h++; end
        check("high_phase", h, CLK_DIV / 2);
        h = 0;
        while (!mic_clk && h < 100) begin step(); h++; end
        check("low_phase", h, CLK_DIV / 2);

        // DC full scale, positive and negative
        start(1);
        push(0, 0, 3);
        push(KPOS, FULL, 6);
        drain("dc_pos", 12 * PERIOD);

        start(0);
        push(0, 0, 3);
        push(KNEG, -FULL, 6);
        drain("dc_neg", 12 * PERIOD);

        // Alternating pattern: zero output, integrators wrap many times
        start(2);
        push(0, 0, 3);
        push(KZERO, 0, 56);
        drain("alt", 64 * PERIOD);

        // Overrun: hold ready low across two sample loads
        start(1);
        push(0, 0, 3);
        push(KPOS, FULL, 1);
        drain("ovr_pre", 8 * PERIOD);
        sample_ready = 1'b0;
        k = 0;
        while (!sample_valid && k < 2 * PERIOD) begin step(); k++; end
        check("ovr_first_valid", int'(sample_valid), 1);
        check("ovr_clear_before", int'(overrun), 0);
        repeat (PERIOD + 16) step();
        check("ovr_set", int'(overrun), 1);
        check("ovr_valid_held", int'(sample_valid), 1);
`ifdef PDM_DC_BLOCK_EN
        check("ovr_sample_positive", int'($signed(sample) > 0), 1);
`else
        check("ovr_sample", int'($signed(sample)), FULL);
`endif
        push(KPOS, FULL, 1);
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
        check("ovr_xfer_seen", exp_q.size(), 0);
        check("ovr_valid_drop", int'(sample_valid), 0);
        check("ovr_sticky", int'(overrun), 1);
        repeat (PERIOD) step();
        check("ovr_sticky_later", int'(overrun), 1);
        enable = 1'b0;
        step();
        check("ovr_cleared_by_enable", int'(overrun), 0);

        // Mid-operation reset during a comb flush
        start(1);
        push(0, 0, 1);
        k = 0;
        while (!sample_valid && k < 2 * PERIOD) begin step(); k++; end
        check("rst_pre_valid", int'(sample_valid), 1);
        repeat (PERIOD - 2) step();
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(sample_valid), 0);
        check("async_rst_sample", int'(sample), 0);
        check("async_rst_overrun", int'(overrun), 0);
        check("async_rst_mic_clk", int'(mic_clk), 0);
        repeat (3) step();
        push(0, 0, 1);
        rst_n = 1'b1;
        k = 0;
        do begin step(); k++; end while (!sample_valid && k < 2 * PERIOD);
        check("rst_first_valid_cycle", k, PERIOD + LAT - 1);
        drain("rst_post", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
